// File: rtl/mac_acc_pipe_pkg.sv
// Shared widths, derived sizes and mode encoding for the multiply-add/accumulate pipeline.
package mac_acc_pipe_pkg;

    localparam int unsigned SIZE_REG      = 8;
    localparam int unsigned SIZE_DATA_OUT = 16;
    localparam int unsigned MAX_ACC_LEN   = 8;

    localparam int unsigned PROD_W    = 2 * SIZE_REG;
    localparam int unsigned ACC_LEN_W = $clog2(MAX_ACC_LEN + 1);
    localparam int unsigned CNT_W     = (MAX_ACC_LEN > 1) ? $clog2(MAX_ACC_LEN) : 1;
    localparam int unsigned ACC_W     = PROD_W + $clog2(MAX_ACC_LEN) + 1;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mac_mode_t;

endpackage

// File: rtl/mac_acc_pipe_if.sv
// Sample-in / result-out bundle of mac_acc_pipe; master drives samples, slave returns results.
interface mac_acc_pipe_if;
    import mac_acc_pipe_pkg::*;

    logic                     in_valid;
    logic [SIZE_REG-1:0]      a;
    logic [SIZE_REG-1:0]      b;
    logic [SIZE_REG-1:0]      c;
    mac_mode_t                mode;
    logic [ACC_LEN_W-1:0]     acc_len;
    logic [PROD_W-1:0]        s;
    logic [SIZE_DATA_OUT-1:0] DATA_OUT;
    logic                     out_valid;
    logic                     ovf;
    logic                     burst_abort;

    modport master (
        output in_valid, a, b, c, mode, acc_len,
        input  s, DATA_OUT, out_valid, ovf, burst_abort
    );

    modport slave (
        input  in_valid, a, b, c, mode, acc_len,
        output s, DATA_OUT, out_valid, ovf, burst_abort
    );

endinterface

// File: rtl/mac_acc_pipe_sat.sv
// Combinational clamp of the wide accumulator onto the output width, flagging overflow.
module mac_sat
    import mac_acc_pipe_pkg::*;
(
    input  logic [ACC_W-1:0]         i_val,
    output logic [SIZE_DATA_OUT-1:0] o_val_c,
    output logic                     o_ovf_c
);

    logic w_over;

    assign w_over  = |i_val[ACC_W-1:SIZE_DATA_OUT];
    assign o_ovf_c = w_over;
    assign o_val_c = w_over ? {SIZE_DATA_OUT{1'b1}} : i_val[SIZE_DATA_OUT-1:0];

endmodule

// File: rtl/mac_acc_pipe.sv
// Two-stage multiply-add / burst multiply-accumulate with saturated output.
module mac_acc_pipe
    import mac_acc_pipe_pkg::*;
(
    input logic          clk,
    input logic          reset,
    mac_acc_pipe_if.slave bus
);

    logic                     r_v1;
    logic [PROD_W-1:0]        r_s;
    logic [SIZE_REG-1:0]      r_c;
    mac_mode_t                r_mode;
    logic [ACC_LEN_W-1:0]     r_acc_len;

    logic [ACC_W-1:0]         r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [ACC_LEN_W-1:0]     r_len;
    logic [SIZE_DATA_OUT-1:0] r_data;
    logic                     r_out_valid;
    logic                     r_ovf;
    logic                     r_abort;

    logic                     w_fresh;
    logic [ACC_W-1:0]         w_sum;
    logic [ACC_LEN_W-1:0]     w_len_first;
    logic [ACC_LEN_W-1:0]     w_len_eff;
    logic                     w_done;
    logic [SIZE_DATA_OUT-1:0] w_sat_val;
    logic                     w_sat_ovf;

    // A new sum starts from the bias c for ADD samples and for the first sample of a burst
    assign w_fresh = (r_mode == MODE_ADD) || (r_cnt == '0);
    assign w_sum   = (w_fresh ? ACC_W'(r_c) : r_acc) + ACC_W'(r_s);

    always_comb begin
        w_len_first = r_acc_len;
        if (r_acc_len == '0) begin
            w_len_first = ACC_LEN_W'(1);
        end else if (r_acc_len > ACC_LEN_W'(MAX_ACC_LEN)) begin
            w_len_first = ACC_LEN_W'(MAX_ACC_LEN);
        end
    end

    assign w_len_eff = (r_cnt == '0) ? w_len_first : r_len;
    assign w_done    = (r_mode == MODE_ADD) ||
                       ((ACC_LEN_W'(r_cnt) + ACC_LEN_W'(1)) == w_len_eff);

    mac_sat u_sat (
        .i_val   (w_sum),
        .o_val_c (w_sat_val),
        .o_ovf_c (w_sat_ovf)
    );

    // Stage 1: product and sideband capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_s       <= '0;
            r_c       <= '0;
            r_mode    <= MODE_ADD;
            r_acc_len <= '0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_s       <= PROD_W'(bus.a) * PROD_W'(bus.b);
                r_c       <= bus.c;
                r_mode    <= bus.mode;
                r_acc_len <= bus.acc_len;
            end
        end
    end

    // Stage 2: add / accumulate, burst bookkeeping and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_abort     <= 1'b0;
            if (r_v1) begin
                if (w_done) begin
                    r_data      <= w_sat_val;
                    r_ovf       <= w_sat_ovf;
                    r_out_valid <= 1'b1;
                    r_abort     <= (r_mode == MODE_ADD) && (r_cnt != '0);
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_len <= w_len_first;
                    end
                end
            end
        end
    end

    assign bus.s           = r_s;
    assign bus.DATA_OUT    = r_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.ovf         = r_ovf;
    assign bus.burst_abort = r_abort;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed and random checks of mac_acc_pipe against a per-sample arithmetic reference.
module tb_mac_acc_pipe;
    import mac_acc_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mac_acc_pipe_if bus ();

    mac_acc_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: burst progress, running sum and latched length
    int unsigned m_cnt;
    longint      m_sum;
    int unsigned m_len;
    longint      m_s;
    longint      m_data;
    logic        p_v;
    longint      p_d;
    logic        p_ovf;
    logic        p_ab;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_sum  = 0;
        m_len  = 0;
        m_s    = 0;
        m_data = 0;
        p_v    = 1'b0;
        p_d    = 0;
        p_ovf  = 1'b0;
        p_ab   = 1'b0;
    endtask

    task automatic cyc(input logic v, input int unsigned av, input int unsigned bv,
                       input int unsigned cv, input logic md, input int unsigned ln);
        logic   nv;
        logic   nab;
        logic   novf;
        longint nd;
        longint res;
        bus.in_valid = v;
        bus.a        = SIZE_REG'(av);
        bus.b        = SIZE_REG'(bv);
        bus.c        = SIZE_REG'(cv);
        bus.mode     = md ? MODE_ACC : MODE_ADD;
        bus.acc_len  = ACC_LEN_W'(ln);
        nv   = 1'b0;
        nab  = 1'b0;
        novf = 1'b0;
        nd   = 0;
        res  = -1;
        if (v) begin
            if (!md) begin
                res   = longint'(av) * longint'(bv) + longint'(cv);
                nab   = (m_cnt != 0);
                m_cnt = 0;
                m_sum = 0;
            end else begin
                if (m_cnt == 0) begin
                    m_len = (ln == 0) ? 1 : ((ln > MAX_ACC_LEN) ? MAX_ACC_LEN : ln);
                    m_sum = longint'(cv);
                end
                m_sum = m_sum + longint'(av) * longint'(bv);
                m_cnt++;
                if (m_cnt == m_len) begin
                    res   = m_sum;
                    m_cnt = 0;
                    m_sum = 0;
                end
            end
            if (res >= 0) begin
                nv   = 1'b1;
                novf = (res > 65535);
                nd   = novf ? 65535 : res;
            end
        end
        @(posedge clk);
        #1;
        if (v) m_s = longint'(av) * longint'(bv);
        if (p_v) m_data = p_d;
        chk("s", 64'(bus.s), m_s);
        chk("out_valid", 64'(bus.out_valid), 64'(p_v));
        chk("DATA_OUT", 64'(bus.DATA_OUT), m_data);
        chk("ovf", 64'(bus.ovf), 64'(p_v & p_ovf));
        chk("burst_abort", 64'(bus.burst_abort), 64'(p_ab));
        p_v   = nv;
        p_d   = nd;
        p_ovf = novf;
        p_ab  = nab;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rst_s", 64'(bus.s), 0);
        chk("rst_DATA_OUT", 64'(bus.DATA_OUT), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_ovf", 64'(bus.ovf), 0);
        chk("rst_burst_abort", 64'(bus.burst_abort), 0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c        = '0;
        bus.mode     = MODE_ADD;
        bus.acc_len  = '0;
        model_clear();
        @(posedge clk);
        do_reset();

        // Simple multiply-add with two-cycle latency
        cyc(1'b1, 3, 4, 5, 1'b0, 0);
        chk("t1_s", 64'(bus.s), 12);
        cyc(1'b0, 0, 0, 0, 1'b0, 0);
        chk("t1_data", 64'(bus.DATA_OUT), 17);
        idle(2);

        // Four-sample burst, then the same burst with a bubble
        cyc(1'b1, 1, 2, 10, 1'b1, 4);
        cyc(1'b1, 3, 4, 0, 1'b1, 7);
        cyc(1'b1, 5, 6, 0, 1'b1, 1);
        cyc(1'b1, 7, 8, 0, 1'b1, 2);
        idle(1);
        chk("t2_data", 64'(bus.DATA_OUT), 110);
        idle(1);
        cyc(1'b1, 1, 2, 10, 1'b1, 4);
        cyc(1'b1, 3, 4, 0, 1'b1, 4);
        idle(3);
        cyc(1'b1, 5, 6, 0, 1'b1, 4);
        cyc(1'b1, 7, 8, 0, 1'b1, 4);
        idle(3);

        // Saturation boundaries
        cyc(1'b1, 255, 255, 255, 1'b0, 0);
        idle(2);
        cyc(1'b1, 255, 255, 0, 1'b1, 2);
        cyc(1'b1, 255, 255, 0, 1'b1, 2);
        idle(1);
        chk("t3_sat", 64'(bus.DATA_OUT), 65535);
        chk("t3_ovf", 64'(bus.ovf), 1);
        idle(1);

        // ADD sample aborting a partial burst
        cyc(1'b1, 1, 1, 0, 1'b1, 4);
        cyc(1'b1, 1, 1, 0, 1'b1, 4);
        cyc(1'b1, 2, 2, 1, 1'b0, 0);
        cyc(1'b1, 1, 1, 0, 1'b1, 1);
        chk("t4_abort", 64'(bus.burst_abort), 1);
        chk("t4_data", 64'(bus.DATA_OUT), 5);
        idle(2);

        // Reset in the middle of a burst
        cyc(1'b1, 9, 9, 0, 1'b1, 3);
        cyc(1'b1, 9, 9, 0, 1'b1, 3);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1, 1, 0, 1'b1, 3);
        idle(3);

        // Zero length and back-to-back ADD
        cyc(1'b1, 2, 3, 4, 1'b1, 0);
        idle(2);
        for (int i = 0; i < 8; i++) cyc(1'b1, i + 1, i + 2, i, 1'b0, 0);
        idle(2);

        // Random mix of modes, lengths, operands and bubbles
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), ($urandom_range(0, 4) != 0), $urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_acc_pipe.md
Name: mac_acc_pipe

Overview:
Parametrised, pipelined multiply-add / multiply-accumulate unit. It is the successor to the fixed two-stage a*b+c datapath. It adds an input valid qualifier, an accumulate-over-N-samples mode, output saturation and an overflow flag, and a synchronous reset. It sits in the arithmetic datapath, fed by sample sources and consumed by downstream registers that sample DATA_OUT on out_valid.

Parameters:
SIZE_REG, 8, operand width of a, b, c (unsigned); value taken from package p
SIZE_DATA_OUT, 16, result width of DATA_OUT; value taken from package p
MAX_ACC_LEN, 8, maximum samples per accumulation burst (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  a/b/c/mode/acc_len are valid this cycle
a  input  SIZE_REG  multiplicand, unsigned
b  input  SIZE_REG  multiplier, unsigned
c  input  SIZE_REG  addend (ADD mode) or initial bias (first sample of ACC burst)
mode  input  1  0 = ADD (single a*b+c), 1 = ACC (burst accumulate)
acc_len  input  clog2(MAX_ACC_LEN+1)  burst length; sampled on first sample of a burst only
s  output  2*SIZE_REG  registered stage-1 product a*b
DATA_OUT  output  SIZE_DATA_OUT  saturated result
out_valid  output  1  one-cycle pulse: DATA_OUT holds a new result
ovf  output  1  valid with out_valid: result was saturated
burst_abort  output  1  one-cycle pulse: a partial ACC burst was discarded

Behaviour:
- Reset (sync, active-high) sets every register to 0: s, DATA_OUT, out_valid, ovf, burst_abort, the stage-1 valid, the accumulator, the sample counter and the latched length. In-flight samples are dropped. Reset has priority over all other events in the same cycle.
- Stage 1, on in_valid: s <= a*b at full 2*SIZE_REG width. c, mode and acc_len are registered alongside, and v1 <= 1. When in_valid=0: v1 <= 0 and s holds its value.
- Stage 2 acts only when v1=1. out_valid, ovf and burst_abort default to 0 every cycle. DATA_OUT holds between results.
- ADD mode at stage 2: r = s + c_r. DATA_OUT <= sat(r) and out_valid <= 1. Latency is 2 cycles from in_valid. Throughput is 1 result/cycle.
- ACC mode, first sample (cnt=0): acc <= c_r + s. len_r <= max(acc_len_r,1), clamped to MAX_ACC_LEN.
- ACC mode, each later sample: acc <= acc + s and cnt increments.
- ACC burst end: on the sample where cnt = len_r-1, DATA_OUT <= sat(acc_next), out_valid <= 1, cnt <= 0, acc <= 0. The result appears 2 cycles after the last sample's in_valid.
- A burst with len 1 behaves exactly like ADD.
- Accumulator width is ACC_W = 2*SIZE_REG + clog2(MAX_ACC_LEN) + 1. Internal arithmetic never wraps.
- Saturation: if r > 2^SIZE_DATA_OUT - 1, then DATA_OUT <= all ones and ovf <= 1. Otherwise DATA_OUT <= r[SIZE_DATA_OUT-1:0] and ovf <= 0.
- Gaps in in_valid do not affect burst state. cnt, acc and len_r hold across bubbles of any length.
- acc_len changes mid-burst are ignored. Only the value on the first sample counts.
- ADD sample arriving while cnt != 0: burst_abort <= 1, and the partial acc and cnt are cleared. The ADD result is produced normally in the same cycle.
- No backpressure. The consumer must accept out_valid every cycle.

Decomposition:
- Package p holds:
  - SIZE_REG and SIZE_DATA_OUT;
  - MAX_ACC_LEN default;
  - derived ACC_W and CNT_W;
  - a typedef enum logic {MODE_ADD, MODE_ACC} mac_mode_t.
- One sub-module, mac_sat, is natural: a combinational ACC_W -> SIZE_DATA_OUT saturator producing value and ovf. Everything else stays in mac_acc_pipe.

Test Plan:
1. ADD: a=3, b=4, c=5, in_valid at cycle 0 -> s=12 at cycle 1; DATA_OUT=17, out_valid=1, ovf=0 at cycle 2.
2. ACC acc_len=4: (a,b) = (1,2),(3,4),(5,6),(7,8) on consecutive cycles, c=10 on the first -> exactly one out_valid, 2 cycles after the 4th sample, with DATA_OUT=110. A 3-cycle bubble between samples 2 and 3 gives the same 110, delayed by 3 cycles.
3. Saturation: ADD with a=255, b=255, c=255 -> DATA_OUT=65280, ovf=0. ACC acc_len=2 with (255,255)x2, c=0 -> 130050 saturates: DATA_OUT=65535, ovf=1.
4. Abort: ACC acc_len=4 with 2 samples, then an ADD sample a=2, b=2, c=1 -> burst_abort and out_valid in the same cycle, DATA_OUT=5. A following ACC acc_len=1 with a=1, b=1, c=0 -> DATA_OUT=1, showing no leftover.
5. Reset mid-burst: ACC acc_len=3 with 2 samples of (9,9), reset high 1 cycle, then 3 samples of (1,1) with c=0 -> all outputs 0 after reset; a single out_valid with DATA_OUT=3.
6. Edge lengths: ACC acc_len=0 with a=2, b=3, c=4 -> treated as 1, DATA_OUT=10. Back-to-back ADD every cycle for 8 cycles -> 8 consecutive out_valid pulses with matching results.
